// File: rtl/sys1_pkg.sv
// sys1_pkg
// Shared constants and types for the System 1 player-input front end.
//   - sysmode bit indices (dual-stick, spinner select)
//   - joystick bit indices for the 16-bit HPS joystick words
//   - input_mode_e: which mapping drives INP0/INP1/INP2
//   - decode_mode(): resolves the mode from the two sysmode bits,
//     spinner taking priority over dual-stick.
package sys1_pkg;

  localparam int SM_DUAL = 3;
  localparam int SM_SPIN = 5;

  localparam int JOY_R    = 0;
  localparam int JOY_L    = 1;
  localparam int JOY_D    = 2;
  localparam int JOY_U    = 3;
  localparam int JOY_T1   = 4;
  localparam int JOY_T2   = 5;
  localparam int JOY_T3   = 6;
  localparam int JOY_DT   = 8;
  localparam int JOY_ST1  = 9;
  localparam int JOY_ST2  = 10;
  localparam int JOY_COIN = 11;

  typedef enum logic [1:0] {
    MODE_STD  = 2'd0,
    MODE_DUAL = 2'd1,
    MODE_SPIN = 2'd2
  } input_mode_e;

  function automatic input_mode_e decode_mode(input logic spin_bit, input logic dual_bit);
    if (spin_bit) begin
      return MODE_SPIN;
    end else if (dual_bit) begin
      return MODE_DUAL;
    end
    return MODE_STD;
  endfunction

endpackage

// File: rtl/sys1_spin_accum.sv
// sys1_spin_accum
// Spinner position accumulator for dial games.
//   Edge-detects the frame strobe and the analog toggle bits, tracks which
//   analog source (spinner or mouse) was heard from last, and keeps the
//   8-bit wrapping spinner position.
// Optional feature macro: SYS1_MOUSE_EN (mouse analog source / select).
// Ports:
//   clk_sys, reset_n   clock, async active-low reset
//   dig_r, dig_l       combined digital right/left
//   dig_fast           fast-step button (T2)
//   strobe             frame strobe (vsync, active high)
//   spinner_in[8:0]    [8] sample toggle, [7:0] signed delta
//   mouse_tog          mouse packet toggle
//   mouse_dx[7:0]      signed mouse X delta
//   strobe_rise        one-cycle strobe rising-edge flag (shared with coin logic)
//   spin_pos[7:0]      current position
//   use_mouse          1 = mouse is the active analog source
module sys1_spin_accum #(
  parameter int DIG_STEP = 5,
  parameter int DIG_FAST = 15
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       dig_r,
  input  logic       dig_l,
  input  logic       dig_fast,
  input  logic       strobe,
  input  logic [8:0] spinner_in,
  input  logic       mouse_tog,
  input  logic [7:0] mouse_dx,
  output logic       strobe_rise,
  output logic [7:0] spin_pos,
  output logic       use_mouse
);

  logic       strobe_prev_q, strobe_prev_d;
  logic       spin_tog_q, spin_tog_d;
  logic [7:0] spin_pos_q, spin_pos_d;
  logic       use_mouse_q, use_mouse_d;
  logic       spin_evt;
  logic       mouse_evt;
  logic [7:0] step;
  logic [7:0] dig_delta;
  logic [7:0] ana_delta;
  logic       unused_mouse;

`ifdef SYS1_MOUSE_EN
  logic mouse_tog_q, mouse_tog_d;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mouse_tog_q <= 1'b0;
    end else begin
      mouse_tog_q <= mouse_tog_d;
    end
  end
`endif

  assign unused_mouse = ^{mouse_tog, mouse_dx};

  // The analog source is chosen from the select value being written this
  // cycle, so the packet that switches the source over is itself counted.
  // Adding an 8-bit delta modulo 256 is identical to adding its sign
  // extension, so no explicit widening is needed.
  always_comb begin
    strobe_prev_d = strobe;
    spin_tog_d    = spinner_in[8];
    strobe_rise   = strobe & ~strobe_prev_q;
    spin_evt      = spinner_in[8] ^ spin_tog_q;

    step      = dig_fast ? 8'(DIG_FAST) : 8'(DIG_STEP);
    dig_delta = 8'd0;
    if (strobe_rise) begin
      if (dig_r && !dig_l) begin
        dig_delta = step;
      end else if (dig_l && !dig_r) begin
        dig_delta = 8'd0 - step;
      end
    end

`ifdef SYS1_MOUSE_EN
    mouse_tog_d = mouse_tog;
    mouse_evt   = mouse_tog ^ mouse_tog_q;
    use_mouse_d = use_mouse_q;
    if (spin_evt) begin
      use_mouse_d = 1'b0;
    end else if (mouse_evt) begin
      use_mouse_d = 1'b1;
    end
`else
    mouse_evt   = 1'b0;
    use_mouse_d = 1'b0;
`endif

    ana_delta = 8'd0;
    if (use_mouse_d) begin
      if (mouse_evt) begin
        ana_delta = mouse_dx;
      end
    end else if (spin_evt) begin
      ana_delta = spinner_in[7:0];
    end

    spin_pos_d = spin_pos_q + dig_delta + ana_delta;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      strobe_prev_q <= 1'b0;
      spin_tog_q    <= 1'b0;
      spin_pos_q    <= 8'd0;
      use_mouse_q   <= 1'b0;
    end else begin
      strobe_prev_q <= strobe_prev_d;
      spin_tog_q    <= spin_tog_d;
      spin_pos_q    <= spin_pos_d;
      use_mouse_q   <= use_mouse_d;
    end
  end

  assign spin_pos  = spin_pos_q;
  assign use_mouse = use_mouse_q;

endmodule

// File: rtl/sys1_input_ctrl.sv
// sys1_input_ctrl
// Player-input front end for the System 1 core. Builds the active-low
// INP0/INP1/INP2 bytes from the joysticks according to the per-game
// sysmode bits, hosts the spinner accumulator and stretches coin presses
// to COIN_FRAMES frame strobes.
// Optional feature macro: SYS1_MOUSE_EN (mouse fire buttons / analog source).
// Ports:
//   clk_sys, reset_n        clock, async active-low reset
//   sysmode[7:0]            [3] dual-stick, [5] spinner
//   joy1[15:0], joy2[15:0]  active-high joystick words
//   spinner_in[8:0]         analog spinner (toggle + delta)
//   ps2_mouse[24:0]         mouse packet (toggle, X delta, buttons)
//   strobe                  frame strobe
//   inp0, inp1, inp2        active-low input bytes (registered)
//   spin_pos[7:0]           spinner position (debug)
//   use_mouse               analog source select
module sys1_input_ctrl #(
  parameter int DIG_STEP    = 5,
  parameter int DIG_FAST    = 15,
  parameter int COIN_FRAMES = 3
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [7:0]  sysmode,
  input  logic [15:0] joy1,
  input  logic [15:0] joy2,
  input  logic [8:0]  spinner_in,
  input  logic [24:0] ps2_mouse,
  input  logic        strobe,
  output logic [7:0]  inp0,
  output logic [7:0]  inp1,
  output logic [7:0]  inp2,
  output logic [7:0]  spin_pos,
  output logic        use_mouse
);

  import sys1_pkg::*;

  localparam int CW = $clog2(COIN_FRAMES + 1);

  logic [15:0]  joy;
  logic [3:0]   right_stick;
  input_mode_e  mode;
  logic         fire;
  logic         strobe_rise;
  logic [7:0]   spin_pos_w;
  logic         coin_rise;
  logic         unused_sink;

  logic [7:0]   inp0_q, inp0_d;
  logic [7:0]   inp2_q, inp2_d;
  logic         coin_q, coin_d;
  logic [CW-1:0] coin_cnt_q, coin_cnt_d;
  logic         coin_prev_q, coin_prev_d;

  assign joy         = joy1 | joy2;
  assign right_stick = joy1[7:4] | joy2[3:0];
  assign mode        = decode_mode(sysmode[SM_SPIN], sysmode[SM_DUAL]);

`ifdef SYS1_MOUSE_EN
  assign fire = joy[JOY_T1] | (|ps2_mouse[2:0]);
`else
  assign fire = joy[JOY_T1];
`endif

  assign unused_sink = ^{sysmode[7:6], sysmode[4], sysmode[2:0], joy[15:12], joy[8:7], ps2_mouse};

  sys1_spin_accum #(
    .DIG_STEP (DIG_STEP),
    .DIG_FAST (DIG_FAST)
  ) u_spin (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .dig_r       (joy[JOY_R]),
    .dig_l       (joy[JOY_L]),
    .dig_fast    (joy[JOY_T2]),
    .strobe      (strobe),
    .spinner_in  (spinner_in),
    .mouse_tog   (ps2_mouse[24]),
    .mouse_dx    (ps2_mouse[15:8]),
    .strobe_rise (strobe_rise),
    .spin_pos    (spin_pos_w),
    .use_mouse   (use_mouse)
  );

  // Coin stretcher: only a fresh press while the counter is idle starts a
  // hold, so presses during a hold (and a coin still held when the hold
  // ends) never retrigger. The output bytes are built from the registered
  // spinner position and coin flag, hence the extra cycle on those paths.
  always_comb begin
    coin_prev_d = joy[JOY_COIN];
    coin_rise   = joy[JOY_COIN] & ~coin_prev_q;
    coin_d      = coin_q;
    coin_cnt_d  = coin_cnt_q;
    if (coin_cnt_q == '0) begin
      if (coin_rise) begin
        coin_d     = 1'b1;
        coin_cnt_d = CW'(COIN_FRAMES);
      end
    end else if (strobe_rise) begin
      coin_cnt_d = coin_cnt_q - CW'(1);
      if (coin_cnt_q == CW'(1)) begin
        coin_d = 1'b0;
      end
    end

    inp0_d = ~{joy[JOY_L], joy[JOY_R], joy[JOY_U], joy[JOY_D], 1'b0,
               joy[JOY_T2], joy[JOY_T1], joy[JOY_T3]};
    inp2_d = ~{2'b00, joy[JOY_ST2], joy[JOY_ST1], 3'b000, coin_q};
    case (mode)
      MODE_DUAL: begin
        inp0_d = ~{joy1[JOY_L], joy1[JOY_R], joy1[JOY_U], joy1[JOY_D],
                   right_stick[JOY_L], right_stick[JOY_R],
                   right_stick[JOY_U], right_stick[JOY_D]};
        inp2_d = ~{joy1[JOY_DT], joy1[JOY_DT], joy[JOY_ST2], joy[JOY_ST1],
                   3'b000, coin_q};
      end
      MODE_SPIN: begin
        inp0_d = ~spin_pos_w;
        inp2_d = ~{fire, fire, joy[JOY_ST2], joy[JOY_ST1], 3'b000, coin_q};
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      inp0_q      <= 8'hFF;
      inp2_q      <= 8'hFF;
      coin_q      <= 1'b0;
      coin_cnt_q  <= '0;
      coin_prev_q <= 1'b0;
    end else begin
      inp0_q      <= inp0_d;
      inp2_q      <= inp2_d;
      coin_q      <= coin_d;
      coin_cnt_q  <= coin_cnt_d;
      coin_prev_q <= coin_prev_d;
    end
  end

  assign inp0     = inp0_q;
  assign inp1     = inp0_q;
  assign inp2     = inp2_q;
  assign spin_pos = spin_pos_w;

endmodule

// File: tb/tb_sys1_input_ctrl.sv
// tb_sys1_input_ctrl
// Directed and randomized checks of sys1_input_ctrl against a frame-level
// behavioural model of the input front end. Mouse expectations follow
// SYS1_MOUSE_EN so the bench is valid in both builds.
module tb_sys1_input_ctrl;

  localparam int COIN_FRAMES = 3;
`ifdef SYS1_MOUSE_EN
  localparam bit MOUSE_EN = 1'b1;
`else
  localparam bit MOUSE_EN = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  sysmode = '0;
  logic [15:0] joy1 = '0;
  logic [15:0] joy2 = '0;
  logic [8:0]  spinner_in = '0;
  logic [24:0] ps2_mouse = '0;
  logic        strobe = 1'b0;
  logic [7:0]  inp0, inp1, inp2, spin_pos;
  logic        use_mouse;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  // Reference state: position as an integer mod 256, frames of coin left,
  // and the previous values of every edge-detected input.
  int         mPos;
  int         mCoinLeft;
  bit         mMouse, mSpinTog, mMouseTog, mStrobePrev, mCoinPrev;
  logic [7:0] mInp0, mInp2;

  always #5 clk_sys = ~clk_sys;

  sys1_input_ctrl #(
    .DIG_STEP    (5),
    .DIG_FAST    (15),
    .COIN_FRAMES (COIN_FRAMES)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .sysmode    (sysmode),
    .joy1       (joy1),
    .joy2       (joy2),
    .spinner_in (spinner_in),
    .ps2_mouse  (ps2_mouse),
    .strobe     (strobe),
    .inp0       (inp0),
    .inp1       (inp1),
    .inp2       (inp2),
    .spin_pos   (spin_pos),
    .use_mouse  (use_mouse)
  );

  task automatic modelReset();
    mPos = 0; mCoinLeft = 0;
    mMouse = 0; mSpinTog = 0; mMouseTog = 0; mStrobePrev = 0; mCoinPrev = 0;
    mInp0 = 8'hFF; mInp2 = 8'hFF;
  endtask

  // Advances the model by one clock using the inputs present at the edge.
  task automatic modelStep();
    logic [15:0] j;
    logic [3:0]  l, r;
    bit rise, sChg, mChg, nextMouse, coinOn, fireBit, cRise;
    int dir, step, dig, ana;
    if (!reset_n) begin
      modelReset();
      return;
    end
    j = joy1 | joy2;
    l = joy1[3:0];
    r = joy1[7:4] | joy2[3:0];
    coinOn  = (mCoinLeft > 0);
    fireBit = j[4] | (MOUSE_EN & (|ps2_mouse[2:0]));
    if (sysmode[5]) begin
      mInp0 = ~8'(mPos);
      mInp2 = ~{fireBit, fireBit, j[10], j[9], 3'b000, coinOn};
    end else if (sysmode[3]) begin
      mInp0 = ~{l[1], l[0], l[3], l[2], r[1], r[0], r[3], r[2]};
      mInp2 = ~{joy1[8], joy1[8], j[10], j[9], 3'b000, coinOn};
    end else begin
      mInp0 = ~{j[1], j[0], j[3], j[2], 1'b0, j[5], j[4], j[6]};
      mInp2 = ~{2'b00, j[10], j[9], 3'b000, coinOn};
    end

    rise = strobe && !mStrobePrev;
    dir  = int'(j[0]) - int'(j[1]);
    step = j[5] ? 15 : 5;
    dig  = rise ? step * dir : 0;
    sChg = (spinner_in[8] != mSpinTog);
    mChg = MOUSE_EN && (ps2_mouse[24] != mMouseTog);
    nextMouse = sChg ? 1'b0 : (mChg ? 1'b1 : mMouse);
    if (nextMouse) ana = mChg ? int'($signed(ps2_mouse[15:8])) : 0;
    else           ana = sChg ? int'($signed(spinner_in[7:0])) : 0;
    mPos = (((mPos + dig + ana) % 256) + 256) % 256;
    mMouse = nextMouse;

    cRise = j[11] && !mCoinPrev;
    if (mCoinLeft == 0) begin
      if (cRise) mCoinLeft = COIN_FRAMES;
    end else if (rise) begin
      mCoinLeft = mCoinLeft - 1;
    end

    mStrobePrev = strobe;
    mCoinPrev   = j[11];
    mSpinTog    = spinner_in[8];
    mMouseTog   = ps2_mouse[24];
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      modelStep();
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] j1, input logic [15:0] j2,
                               input logic [7:0] sm, input logic st);
    joy1 = j1; joy2 = j2; sysmode = sm; strobe = st;
  endtask

  task automatic strobePulse();
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    tick();
  endtask

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".inp0"}, inp0, mInp0);
    checkVal({tag, ".inp1"}, inp1, mInp0);
    checkVal({tag, ".inp2"}, inp2, mInp2);
    checkVal({tag, ".spin_pos"}, spin_pos, 8'(mPos));
    checkVal({tag, ".use_mouse"}, {7'd0, use_mouse}, {7'd0, mMouse});
  endtask

  task automatic resetDut();
    reset_n = 1'b0;
    applyStimulus(16'h0, 16'h0, 8'h00, 1'b0);
    spinner_in = '0;
    ps2_mouse  = '0;
    tick(2);
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    int lowFrames;
    logic [7:0] expPos;
    logic [7:0] expMouse;

    modelReset();
    $display("[TB] start");

    // Reset values.
    tick(2);
    checkVal("reset.inp0", inp0, 8'hFF);
    checkVal("reset.inp2", inp2, 8'hFF);
    checkVal("reset.spin_pos", spin_pos, 8'h00);
    checkOutput("reset");
    reset_n = 1'b1;
    tick();

    // Standard mode: up + T1.
    applyStimulus(16'h0018, 16'h0000, 8'h00, 1'b0);
    tick();
    checkVal("std.inp0", inp0, 8'hDD);
    checkVal("std.inp1", inp1, 8'hDD);
    checkVal("std.inp2", inp2, 8'hFF);
    checkOutput("std");

    // Dual-stick: left up from joy1, right-stick right from joy2.
    applyStimulus(16'h0008, 16'h0001, 8'h08, 1'b0);
    tick();
    checkVal("dual.inp0", inp0, 8'hDB);
    checkOutput("dual");

    // Spinner digital: R for three frames, then fast left for one.
    applyStimulus(16'h0001, 16'h0000, 8'h20, 1'b0);
    repeat (3) strobePulse();
    checkVal("spin_r.spin_pos", spin_pos, 8'h0F);
    checkVal("spin_r.inp0", inp0, 8'hF0);
    checkOutput("spin_r");
    applyStimulus(16'h0022, 16'h0000, 8'h20, 1'b0);
    strobePulse();
    checkVal("spin_fastl.spin_pos", spin_pos, 8'h00);
    checkOutput("spin_fastl");

    // Spinner analog wrap.
    applyStimulus(16'h0000, 16'h0000, 8'h20, 1'b0);
    spinner_in = {1'b1, 8'hFB};
    tick();
    checkVal("ana.fb", spin_pos, 8'hFB);
    spinner_in = {1'b0, 8'h05};
    tick();
    checkVal("ana.wrap", spin_pos, 8'h00);
    checkOutput("ana");

    // Mouse delta coinciding with a +5 strobe, from 0x10.
    spinner_in = {1'b1, 8'h10};
    tick();
    checkVal("mix.start", spin_pos, 8'h10);
    applyStimulus(16'h0001, 16'h0000, 8'h20, 1'b1);
    ps2_mouse = {1'b1, 8'h00, 8'hF0, 8'h00};
    tick();
    expPos   = MOUSE_EN ? 8'h05 : 8'h15;
    expMouse = MOUSE_EN ? 8'h01 : 8'h00;
    checkVal("mix.spin_pos", spin_pos, expPos);
    checkVal("mix.use_mouse", {7'd0, use_mouse}, expMouse);
    strobe = 1'b0;
    tick();
    checkOutput("mix");

    // Coin held ten frames, with a re-press during the hold.
    resetDut();
    applyStimulus(16'h0800, 16'h0000, 8'h00, 1'b0);
    tick(2);
    checkVal("coin.start", inp2, 8'hFE);
    lowFrames = 0;
    for (int f = 0; f < 10; f++) begin
      if (inp2[0] == 1'b0) lowFrames++;
      checkOutput("coin.hold");
      if (f == 1) begin
        joy1 = 16'h0000;
        tick();
        joy1 = 16'h0800;
        tick();
      end
      strobePulse();
      tick();
    end
    checkVal("coin.frames", 8'(lowFrames), 8'd3);

    // Release and press again after the hold: a second full pulse.
    joy1 = 16'h0000;
    tick();
    joy1 = 16'h0800;
    tick(2);
    checkVal("coin2.start", inp2, 8'hFE);
    lowFrames = 0;
    for (int f = 0; f < 5; f++) begin
      if (inp2[0] == 1'b0) lowFrames++;
      strobePulse();
      tick();
    end
    checkVal("coin2.frames", 8'(lowFrames), 8'd3);
    checkOutput("coin2");

    // Reset in the middle of a hold clears it immediately.
    joy1 = 16'h0000;
    tick();
    joy1 = 16'h0800;
    tick(2);
    strobePulse();
    checkVal("coinrst.before", inp2, 8'hFE);
    reset_n = 1'b0;
    #1;
    modelReset();
    checkVal("coinrst.async", inp2, 8'hFF);
    checkOutput("coinrst.async");
    joy1 = 16'h0000;
    tick(2);
    reset_n = 1'b1;
    tick();
    for (int f = 0; f < 4; f++) begin
      checkVal("coinrst.nopulse", inp2, 8'hFF);
      strobePulse();
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      joy1 = 16'($urandom) & 16'($urandom) & 16'($urandom);
      joy2 = 16'($urandom) & 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: sysmode = 8'h00;
          1: sysmode = 8'h08;
          2: sysmode = 8'h20;
          default: sysmode = 8'h28;
        endcase
      end
      if ($urandom_range(0, 3) == 0) strobe = ~strobe;
      if ($urandom_range(0, 7) == 0) spinner_in = {~spinner_in[8], 8'($urandom)};
      if ($urandom_range(0, 7) == 0)
        ps2_mouse = {~ps2_mouse[24], 8'($urandom), 8'($urandom), 5'd0, 3'($urandom)};
      tick();
      checkOutput("rnd");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
